lsu_byte_master: RTL and testbench

- Load/store unit in the CPU MEM stage. It is the initiator side of the byte-addressed data memory port.
- Accepts one word, halfword or byte access per request and serialises it into single-byte memory transactions, one per cycle, little-endian.
- Assembles read bytes and sign- or zero-extends them. Signals completion to the pipeline, which stalls while ready_o is low.

---
 rtl/lsu_byte_master.sv | 140 ++++++++++++++
 tb/tb_lsu_byte_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_master.sv
// Load/store unit: serialises byte/half/word accesses into little-endian single-byte transactions.
// Optional misaligned-access rejection is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_byte_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              ready_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  input  logic [7:0]        mem_data_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q;
  logic              write_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        cnt_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       rdata_q;
  logic              we_q;
  logic              re_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;

  logic [1:0]        last_idx;
  logic [1:0]        cnt_nxt;
  logic [31:0]       asm_d;
  logic [31:0]       ext_d;

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;
  logic misaligned;
  assign misaligned = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
  assign resp_err_o = err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  always_comb begin
    last_idx = size_q[1] ? 2'd3 : {1'b0, size_q[0]};
    cnt_nxt  = cnt_q + 2'd1;
    asm_d    = asm_q;
    asm_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
    unique case (size_q)
      2'b00:   ext_d = uns_q ? {24'h0, asm_d[7:0]} : {{24{asm_d[7]}}, asm_d[7:0]};
      2'b01:   ext_d = uns_q ? {16'h0, asm_d[15:0]} : {{16{asm_d[15]}}, asm_d[15:0]};
      default: ext_d = asm_d;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      cnt_q   <= 2'd0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            uns_q   <= req_unsigned_i;
            size_q  <= req_size_i;
            wdata_q <= req_wdata_i;
            cnt_q   <= 2'd0;
            asm_q   <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            if (misaligned) begin
              state_q <= StResp;
              err_q   <= 1'b1;
            end else
`endif
            begin
              state_q <= StAccess;
              addr_q  <= req_addr_i;
              data_q  <= req_wdata_i[7:0];
              we_q    <= req_write_i;
              re_q    <= !req_write_i;
            end
          end
        end
        StAccess: begin
          if (!write_q) asm_q <= asm_d;
          if (cnt_q == last_idx) begin
            state_q <= StResp;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            if (!write_q) rdata_q <= ext_d;
          end else begin
            cnt_q  <= cnt_nxt;
            addr_q <= addr_q + ADDR_W'(1);
            data_q <= wdata_q[{cnt_nxt, 3'b000} +: 8];
          end
        end
        default: begin
          state_q <= StIdle;
`ifdef LSU_MISALIGN_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign ready_o      = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign mem_we_o     = we_q;
  assign mem_re_o     = re_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed table-driven bench for lsu_byte_master with a 256-byte memory model (low address bits).
module tb_lsu_byte_master;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          n;
    logic        mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        ready_o, resp_valid_o, resp_err_o, mem_we_o, mem_re_o;
  logic [31:0] resp_rdata_o, mem_addr_o;
  logic [7:0]  mem_data_o, mem_data_i;
  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  lsu_byte_master #(.ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_write_i    (req_write),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .ready_o        (ready_o),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_we_o       (mem_we_o),
    .mem_re_o       (mem_re_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i)
  );

  always #5 clk = ~clk;

  assign mem_data_i = mem_re_o ? mem[mem_addr_o[7:0]] : 8'h00;

  always @(posedge clk) if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_data_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int k;
    int en;
    logic rej;
    rej = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    rej = v.mis;
`endif
    en = rej ? 0 : v.n;
    @(negedge clk);
    check($sformatf("v%0d ready_before", idx), {31'h0, ready_o}, 32'h1);
    req_write = v.write; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    k = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_we_o || mem_re_o) begin
        check($sformatf("v%0d addr%0d", idx, k), mem_addr_o, v.addr + 32'(k));
        check($sformatf("v%0d we%0d", idx, k), {31'h0, mem_we_o}, {31'h0, v.write});
        if (v.write)
          check($sformatf("v%0d data%0d", idx, k), {24'h0, mem_data_o}, {24'h0, v.wdata[8*k +: 8]});
        k++;
      end
    end while (!resp_valid_o && cyc < 20);
    check($sformatf("v%0d latency", idx), 32'(cyc), 32'(en + 1));
    check($sformatf("v%0d strobes", idx), 32'(k), 32'(en));
    check($sformatf("v%0d err", idx), {31'h0, resp_err_o}, {31'h0, rej});
    check($sformatf("v%0d rdata", idx), resp_rdata_o, v.rdata);
    @(negedge clk);
    check($sformatf("v%0d ready_after", idx), {31'h0, ready_o}, 32'h1);
  endtask

  vec_t tbl [15];

  initial begin
    int pulses;
    logic [6:0] rv;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    //        write size  uns  addr          wdata          rdata          n  mis
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 4, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFFAD, 1, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h000000AD, 1, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 2, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 4, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, 32'h20, 32'h12348001, 32'hDEADBEEF, 2, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h00008001, 2, 1'b0};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        32'hFFFF8001, 2, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'hFFFFFF80, 1, 1'b0};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 32'h22, 32'hAABBCC55, 32'hFFFFFF80, 1, 1'b0};
    tbl[10] = '{1'b0, 2'b10, 1'b1, 32'h20, 32'h0,        32'h00558001, 4, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 4, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h01020304, 32'hDEADBEEF, 4, 1'b1};
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        32'hDEADBEEF, 4, 1'b1};
    tbl[14] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0,  32'hDEADBEEF, 4, 1'b1};
`else
    tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        32'h00DEADBE, 4, 1'b1};
    tbl[14] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0,  32'h01020304, 4, 1'b1};
`endif

    // Reset state
    #12;
    check("rst_ctrl", {26'h0, ready_o, resp_valid_o, resp_err_o, mem_we_o, mem_re_o, 1'b0},
          32'h20);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", {24'h0, mem_data_o}, 32'h0);
    check("rst_rdata", resp_rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(tbl[i], i);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    rv = '0;
    rv[0] = ready_o;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      rv[i] = ready_o;
    end
    check("b2b_ready_pattern", {25'h0, rv}, 32'h41);
    @(posedge clk);
    #1 req_valid = 1'b0;
    pulses = 0;
    while (!resp_valid_o && pulses < 20) begin
      @(negedge clk);
      pulses++;
    end
    check("b2b_second_latency", 32'(pulses), 32'd5);
    check("b2b_rdata", resp_rdata_o, 32'hDEADBEEF);

    // Reset during byte 2 of a word store
    @(negedge clk);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_we_before", {31'h0, mem_we_o}, 32'h1);
    check("abort_addr_before", mem_addr_o, 32'h42);
    rst = 1'b0;
    #1;
    check("abort_we_now", {31'h0, mem_we_o}, 32'h0);
    check("abort_ready_now", {31'h0, ready_o}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid_o || mem_we_o) pulses++;
    end
    check("abort_no_activity", 32'(pulses), 32'd0);
    check("abort_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0000F00D);
    check("abort_ready", {31'h0, ready_o}, 32'h1);
    check("abort_rdata", resp_rdata_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
